video_capture_ctrl: RTL and testbench

Synthesizable sequencer that selects one video frame from the pixel stream and drives a byte-addressed capture buffer with it. It counts frame boundaries, skips a programmed number of frames after an arm request, then writes exactly one frame's active pixels as RGB byte triplets. It also checks line width and line count against the configured geometry. It sits between the video timing/stitching output and the frame capture memory, which is later dumped to a BMP.

---
 rtl/video_capture_ctrl_if.sv | 42 ++++
 rtl/video_capture_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_video_capture_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_capture_ctrl_if.sv
// video_capture_ctrl_if
//   Bundles the video input stream, the capture control handshake and the
//   capture-buffer write port of video_capture_ctrl.
//   master : the capture controller (consumes video + control, drives the
//            buffer write port and status)
//   slave  : the environment (video source, control host, capture memory)
//   Signals:
//     video_vsync/hsync/de/data : pixel stream from timing/stitching
//     arm, skip_frames, abort   : capture request / skip count / cancel
//     busy, cap_done, err_geom  : status
//     cap_we, cap_addr, cap_data: byte-addressed capture buffer write
interface video_capture_ctrl_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 20,
  parameter int SKIP_WIDTH = 3
);
  logic                  video_vsync;
  logic                  video_hsync;
  logic                  video_de;
  logic [DATA_WIDTH-1:0] video_data;
  logic                  arm;
  logic [SKIP_WIDTH-1:0] skip_frames;
  logic                  abort;
  logic                  busy;
  logic                  cap_we;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  cap_done;
  logic [2:0]            err_geom;

  modport master (
    input  video_vsync, video_hsync, video_de, video_data,
    input  arm, skip_frames, abort,
    output busy, cap_we, cap_addr, cap_data, cap_done, err_geom
  );

  modport slave (
    output video_vsync, video_hsync, video_de, video_data,
    output arm, skip_frames, abort,
    input  busy, cap_we, cap_addr, cap_data, cap_done, err_geom
  );
endinterface

// File: rtl/video_capture_ctrl.sv
// video_capture_ctrl
//   Picks one frame out of the video stream and writes its active pixels into
//   a byte-addressed capture buffer as RGB triplets (R at cap_addr, G/B at
//   +1/+2). After arm, skip_frames start-of-frame events are let pass, the
//   next frame is captured, and its line width / line count are checked
//   against IMG_HDISP x IMG_VDISP.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : video_capture_ctrl_if.master (video in, control, buffer write,
//            status: busy, cap_done pulse, sticky err_geom
//            [0]=line width, [1]=line count, [2]=pixel overflow)
module video_capture_ctrl #(
  parameter int IMG_HDISP  = 640,
  parameter int IMG_VDISP  = 480,
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 20,
  parameter int SKIP_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  video_capture_ctrl_if.master bus
);

  localparam int FRAME_BYTES = 3 * IMG_HDISP * IMG_VDISP;
  // One spare bit so the address can reach FRAME_BYTES even when the frame
  // exactly fills the address space; this is what keeps it from wrapping.
  localparam int PA_W = ADDR_WIDTH + 1;
  localparam int HC_W = $clog2(IMG_HDISP + 2);
  localparam int LC_W = $clog2(IMG_VDISP + 2);

  localparam logic [PA_W-1:0] PA_LIMIT = PA_W'(FRAME_BYTES);
  localparam logic [HC_W-1:0] H_EXP    = HC_W'(IMG_HDISP);
  localparam logic [HC_W-1:0] H_SAT    = HC_W'(IMG_HDISP + 1);
  localparam logic [LC_W-1:0] L_EXP    = LC_W'(IMG_VDISP);
  localparam logic [LC_W-1:0] L_SAT    = LC_W'(IMG_VDISP + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  vsync_d1_q, vsync_d1_d;
  logic                  de_d1_q, de_d1_d;
  logic [SKIP_WIDTH-1:0] skip_cnt_q, skip_cnt_d;
  logic [PA_W-1:0]       pix_addr_q, pix_addr_d;
  logic [HC_W-1:0]       h_cnt_q, h_cnt_d;
  logic [LC_W-1:0]       line_cnt_q, line_cnt_d;
  logic [2:0]            err_q, err_d;
  logic                  cap_we_q, cap_we_d;
  logic [ADDR_WIDTH-1:0] cap_addr_q, cap_addr_d;
  logic [DATA_WIDTH-1:0] cap_data_q, cap_data_d;

  logic sof, eol, pixel;
  logic busy_o, done_o;

  // hsync carries no information the controller needs.
  logic unused_hsync;
  assign unused_hsync = bus.video_hsync;

  assign sof   = vsync_d1_q & ~bus.video_vsync;
  assign eol   = de_d1_q & ~bus.video_de;
  assign pixel = bus.video_de & ~sof;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (bus.arm) state_d = S_ARMED;
        S_ARMED:   if (sof && skip_cnt_q == '0) state_d = S_CAPTURE;
        S_CAPTURE: if (sof) state_d = S_DONE;
        S_DONE:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      S_ARMED, S_CAPTURE: busy_o = 1'b1;
      S_DONE:             done_o = 1'b1;
      default:            ;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_comb begin
    vsync_d1_d = bus.video_vsync;
    de_d1_d    = bus.video_de;
    skip_cnt_d = skip_cnt_q;
    pix_addr_d = pix_addr_q;
    h_cnt_d    = h_cnt_q;
    line_cnt_d = line_cnt_q;
    err_d      = err_q;
    cap_we_d   = 1'b0;
    cap_addr_d = cap_addr_q;
    cap_data_d = cap_data_q;

    // abort freezes everything (err_geom included) and also drops a pixel
    // sampled in the abort cycle itself.
    if (!bus.abort) begin
      case (state_q)
        S_IDLE: begin
          if (bus.arm) begin
            skip_cnt_d = bus.skip_frames;
            pix_addr_d = '0;
            h_cnt_d    = '0;
            line_cnt_d = '0;
            err_d      = '0;
          end
        end
        S_ARMED: begin
          if (sof && skip_cnt_q != '0) skip_cnt_d = skip_cnt_q - SKIP_WIDTH'(1);
        end
        S_CAPTURE: begin
          if (pixel) begin
            if (pix_addr_q < PA_LIMIT) begin
              cap_we_d   = 1'b1;
              cap_addr_d = pix_addr_q[ADDR_WIDTH-1:0];
              cap_data_d = bus.video_data;
              pix_addr_d = pix_addr_q + PA_W'(3);
            end else begin
              err_d[2] = 1'b1;
            end
            if (h_cnt_q != H_SAT) h_cnt_d = h_cnt_q + HC_W'(1);
          end
          // eol needs de low, so it never coincides with a pixel.
          if (eol) begin
            if (h_cnt_q != H_EXP) err_d[0] = 1'b1;
            h_cnt_d = '0;
            if (line_cnt_q != L_SAT) line_cnt_d = line_cnt_q + LC_W'(1);
          end
          // Uses the count before any eol in this cycle: a line still open
          // at the terminating SOF does not count.
          if (sof && line_cnt_q != L_EXP) err_d[1] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_d1_q <= 1'b0;
      de_d1_q    <= 1'b0;
      skip_cnt_q <= '0;
      pix_addr_q <= '0;
      h_cnt_q    <= '0;
      line_cnt_q <= '0;
      err_q      <= '0;
      cap_we_q   <= 1'b0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
    end else begin
      vsync_d1_q <= vsync_d1_d;
      de_d1_q    <= de_d1_d;
      skip_cnt_q <= skip_cnt_d;
      pix_addr_q <= pix_addr_d;
      h_cnt_q    <= h_cnt_d;
      line_cnt_q <= line_cnt_d;
      err_q      <= err_d;
      cap_we_q   <= cap_we_d;
      cap_addr_q <= cap_addr_d;
      cap_data_q <= cap_data_d;
    end
  end

  assign bus.busy     = busy_o;
  assign bus.cap_done = done_o;
  assign bus.cap_we   = cap_we_q;
  assign bus.cap_addr = cap_addr_q;
  assign bus.cap_data = cap_data_q;
  assign bus.err_geom = err_q;

endmodule

// File: tb/tb_video_capture_ctrl.sv
module tb_video_capture_ctrl;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int DW = 24;
  localparam int AW = 8;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_capture_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SKIP_WIDTH(SW)) bus ();

  video_capture_ctrl #(
    .IMG_HDISP(H), .IMG_VDISP(V), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SKIP_WIDTH(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: pixels of the frame that should land in the buffer, in order.
  logic [DW-1:0] exp_q[$];
  // Observed buffer writes / completion.
  logic [AW-1:0] act_addr[$];
  logic [DW-1:0] act_data[$];
  int            act_cyc[$];
  int            done_n = 0;
  int            done_cyc = 0;
  logic [2:0]    done_err = '0;

  int frame_no = 0;
  int last_sof_cyc = 0;
  int abort_cyc = 0;
  int g_lines;
  int g_len[6];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cap_we) begin
        act_addr.push_back(bus.cap_addr);
        act_data.push_back(bus.cap_data);
        act_cyc.push_back(cyc);
      end
      if (bus.cap_done) begin
        done_n   = done_n + 1;
        done_cyc = cyc;
        done_err = bus.err_geom;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic vs, input logic d, input logic [DW-1:0] dat,
                     input logic a, input logic ab);
    @(negedge clk);
    bus.video_vsync = vs;
    bus.video_hsync = ~d;
    bus.video_de    = d;
    bus.video_data  = dat;
    bus.arm         = a;
    bus.abort       = ab;
  endtask

  task automatic blank(input int n);
    repeat (n) drv(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic sof_pulse();
    drv(1'b1, 1'b0, '0, 1'b0, 1'b0);
    drv(1'b1, 1'b0, '0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, '0, 1'b0, 1'b0);
    last_sof_cyc = cyc;
    frame_no++;
  endtask

  task automatic set_good();
    g_lines = V;
    for (int l = 0; l < 6; l++) g_len[l] = H;
  endtask

  // One frame (SOF through trailing blanking); the next SOF closes it.
  task automatic drive_frame(input bit cap, input bit use_geom, input int abort_pix,
                             input bit arm_mid);
    int nl, len, pix;
    logic [DW-1:0] d;
    logic [7:0] tag;
    sof_pulse();
    blank(2);
    nl  = use_geom ? g_lines : V;
    pix = 0;
    tag = frame_no[7:0];
    for (int l = 0; l < nl; l++) begin
      len = use_geom ? g_len[l] : H;
      for (int p = 0; p < len; p++) begin
        d = {tag, 16'($urandom)};
        drv(1'b0, 1'b1, d, arm_mid && pix == 5, pix == abort_pix);
        if (pix == abort_pix) abort_cyc = cyc;
        if (cap && (abort_pix < 0 || pix < abort_pix)) exp_q.push_back(d);
        pix++;
      end
      blank($urandom_range(3, 1));
    end
    blank(2);
  endtask

  task automatic arm_it(input int skip);
    @(negedge clk);
    bus.arm         = 1'b1;
    bus.abort       = 1'b0;
    bus.video_de    = 1'b0;
    bus.video_vsync = 1'b0;
    bus.skip_frames = SW'(skip);
    @(negedge clk);
    check("busy_rise", bus.busy, 1);
    check("err_clr", bus.err_geom, 0);
    bus.arm = 1'b0;
  endtask

  task automatic run_capture(input int skip, input bit arm_mid);
    int base_w, base_d, npix, n_exp, tsof;
    bit e0;
    logic [2:0] exp_err;
    exp_q.delete();
    base_w = act_addr.size();
    base_d = done_n;
    arm_it(skip);
    for (int f = 0; f <= skip; f++) drive_frame(f == skip, f == skip, -1, arm_mid && f == skip);
    sof_pulse();
    tsof = last_sof_cyc;
    blank(3);
    npix = 0;
    e0   = 1'b0;
    for (int l = 0; l < g_lines; l++) begin
      npix += g_len[l];
      if (g_len[l] != H) e0 = 1'b1;
    end
    exp_err = {npix > H * V, g_lines != V, e0};
    n_exp   = (npix > H * V) ? H * V : npix;
    check("n_writes", act_addr.size() - base_w, n_exp);
    for (int i = 0; i < n_exp && base_w + i < act_addr.size(); i++) begin
      check("wr_addr", act_addr[base_w + i], 3 * i);
      check("wr_data", act_data[base_w + i], exp_q[i]);
    end
    check("n_done", done_n - base_d, 1);
    check("done_cyc", done_cyc, tsof + 1);
    check("err_geom", done_err, exp_err);
    check("busy_end", bus.busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int base_w, base_d, late;
    bus.video_vsync = 1'b0;
    bus.video_hsync = 1'b1;
    bus.video_de    = 1'b0;
    bus.video_data  = '0;
    bus.arm         = 1'b0;
    bus.skip_frames = '0;
    bus.abort       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_we", bus.cap_we, 0);
    check("rst_addr", bus.cap_addr, 0);
    check("rst_data", bus.cap_data, 0);
    check("rst_done", bus.cap_done, 0);
    check("rst_err", bus.err_geom, 0);
    rst = 1'b0;
    blank(3);

    // Well-formed frames, no skip and skip of 2.
    set_good();
    run_capture(0, 1'b0);
    run_capture(2, 1'b0);
    // Short line 2: 31 writes ending at 90, width error only.
    set_good();
    g_len[2] = 7;
    run_capture(0, 1'b0);
    // Five full lines: writes stop at 93, count + overflow errors.
    set_good();
    g_lines = 5;
    run_capture(1, 1'b0);
    // arm pulsed during capture is ignored.
    set_good();
    run_capture(0, 1'b1);

    // arm + abort together in IDLE: nothing starts.
    @(negedge clk);
    bus.arm = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    check("armabort_busy0", bus.busy, 0);
    base_w = act_addr.size();
    base_d = done_n;
    drive_frame(1'b0, 1'b0, -1, 1'b0);
    sof_pulse();
    blank(3);
    check("armabort_nwr", act_addr.size() - base_w, 0);
    check("armabort_ndone", done_n - base_d, 0);

    // Abort mid line 1 (line 0 short so err_geom[0] is already set).
    set_good();
    g_len[0] = 7;
    exp_q.delete();
    base_w = act_addr.size();
    base_d = done_n;
    arm_it(0);
    drive_frame(1'b1, 1'b1, 12, 1'b0);
    check("abort_busy", bus.busy, 0);
    check("abort_err_kept", bus.err_geom, 3'b001);
    check("abort_nwr", act_addr.size() - base_w, 12);
    late = 0;
    for (int i = base_w; i < act_addr.size(); i++) if (act_cyc[i] > abort_cyc) late++;
    check("abort_late_we", late, 0);
    for (int i = 0; i < 12 && base_w + i < act_addr.size(); i++)
      check("abort_wr_addr", act_addr[base_w + i], 3 * i);
    sof_pulse();
    blank(3);
    check("abort_no_done", done_n - base_d, 0);
    set_good();
    run_capture(0, 1'b0);

    // Randomized geometry / skip / stray arm.
    for (int it = 0; it < 6; it++) begin
      g_lines = $urandom_range(5, 3);
      for (int l = 0; l < 6; l++) g_len[l] = ($urandom % 2) ? H : $urandom_range(9, 7);
      run_capture($urandom_range(2, 0), 1'($urandom % 2));
    end

    // Asynchronous reset in the middle of a capture.
    set_good();
    arm_it(0);
    sof_pulse();
    blank(2);
    repeat (5) drv(1'b0, 1'b1, 24'hA5A5A5, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_we", bus.cap_we, 0);
    check("arst_addr", bus.cap_addr, 0);
    check("arst_data", bus.cap_data, 0);
    check("arst_err", bus.err_geom, 0);
    @(negedge clk);
    bus.video_de = 1'b0;
    rst = 1'b0;
    blank(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
